// File: rtl/wd_pkg.sv
// Shared definitions for the write-data store sequencer: FSM encoding,
// memory access-size codes and default burst length.
package wd_pkg;
  localparam int WD_MAX_BEATS = 16;

  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRIVE,
    ST_DONE,
    ST_ABRT
  } wd_state_e;
endpackage

// File: rtl/wd_beat_cnt.sv
// Loadable beat down-counter. Oversized loads are clamped to MAX_BEATS;
// last_o flags that the beat now on the bus is the final one.
module wd_beat_cnt #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             dec_i,
  output logic             last_o
);
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = (cnt_i > MAXV) ? MAXV : cnt_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q <= ONE);
endmodule

// File: rtl/wd_seq.sv
// Store-burst sequencer: loads the write-data register per beat, then drives
// one memory write cycle per word, honouring wait states and aborts.
module wd_seq
  import wd_pkg::*;
#(
  parameter int MAX_BEATS = WD_MAX_BEATS,
  parameter int CNT_W     = 5
) (
  input  logic             sysclk,
  input  logic             nRESET,
  input  logic             st_req,
  input  logic [CNT_W-1:0] st_count,
  input  logic             st_byte,
  output logic             st_ack,
  input  logic             wd_valid,
  output logic             WD_Load,
  output logic             WD_DBE,
  output logic             nMREQ,
  output logic             nRW,
  output logic [1:0]       MAS,
  input  logic             nWAIT,
  input  logic             ABORT,
  output logic             addr_inc,
  output logic             st_done,
  output logic             st_abort,
  output logic             busy
);
  wd_state_e state_q, state_d;
  logic      byte_q, byte_d;
  logic      cnt_load, cnt_dec, cnt_last;

  wd_beat_cnt #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) u_cnt (
    .clk_i  (sysclk),
    .rst_ni (nRESET),
    .load_i (cnt_load),
    .cnt_i  (st_count),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    st_ack   = 1'b0;
    WD_Load  = 1'b0;
    addr_inc = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ack is masked while reset is held so no pulse escapes during reset
        if (st_req && nRESET) begin
          st_ack   = 1'b1;
          cnt_load = 1'b1;
          byte_d   = st_byte;
          state_d  = (st_count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        WD_Load = wd_valid;
        if (wd_valid) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        // ABORT only counts once the memory stops waiting
        if (nWAIT) begin
          if (ABORT) begin
            state_d = ST_ABRT;
          end else begin
            addr_inc = 1'b1;
            cnt_dec  = 1'b1;
            state_d  = cnt_last ? ST_DONE : ST_LOAD;
          end
        end
      end
      ST_DONE, ST_ABRT: state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      byte_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

  // Bus controls decode from registers only, so they are glitch-free
  logic drive;
  assign drive    = (state_q == ST_DRIVE);
  assign nMREQ    = ~drive;
  assign nRW      = drive;
  assign WD_DBE   = drive;
  assign MAS      = (drive && byte_q) ? MAS_BYTE : MAS_WORD;
  assign st_done  = (state_q == ST_DONE);
  assign st_abort = (state_q == ST_ABRT);
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_wd_seq.sv
// Directed bench for wd_seq: one task per scenario with hand-computed
// expectations and pulse counters sampled on the falling edge.
module tb_wd_seq;
  logic       sysclk, nRESET, st_req, st_byte, st_ack, wd_valid;
  logic [4:0] st_count;
  logic       WD_Load, WD_DBE, nMREQ, nRW, nWAIT, ABORT;
  logic [1:0] MAS;
  logic       addr_inc, st_done, st_abort, busy;

  int total = 0, bad = 0;
  int n_ainc = 0, n_load = 0, n_done = 0, n_abort = 0, n_drive = 0, n_mas00 = 0;

  wd_seq dut (
    .sysclk(sysclk), .nRESET(nRESET), .st_req(st_req), .st_count(st_count),
    .st_byte(st_byte), .st_ack(st_ack), .wd_valid(wd_valid), .WD_Load(WD_Load),
    .WD_DBE(WD_DBE), .nMREQ(nMREQ), .nRW(nRW), .MAS(MAS), .nWAIT(nWAIT),
    .ABORT(ABORT), .addr_inc(addr_inc), .st_done(st_done), .st_abort(st_abort),
    .busy(busy)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(negedge sysclk) begin
    if (addr_inc) n_ainc++;
    if (WD_Load)  n_load++;
    if (st_done)  n_done++;
    if (st_abort) n_abort++;
    if (!nMREQ)   n_drive++;
    if (!nMREQ && MAS == 2'b00) n_mas00++;
  end

  task automatic tick();
    @(posedge sysclk); #1;
  endtask

  // Present a request for one cycle starting at posedge+1; returns with the
  // FSM one edge past the ack.
  task automatic start(input logic [4:0] c, input logic b, output logic ack);
    st_req = 1'b1; st_count = c; st_byte = b;
    #1 ack = st_ack;
    tick();
    st_req = 1'b0;
  endtask

  task automatic wait_end(input int max, output int n);
    for (n = 0; n < max; n++) begin
      if (st_done || st_abort) break;
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (WD_DBE !== 1'b0)   begin bad++; $display("FAIL rst_dbe got=%b want=0", WD_DBE); end
    total++; if (nMREQ !== 1'b1)    begin bad++; $display("FAIL rst_nmreq got=%b want=1", nMREQ); end
    total++; if (nRW !== 1'b0)      begin bad++; $display("FAIL rst_nrw got=%b want=0", nRW); end
    total++; if (MAS !== 2'b10)     begin bad++; $display("FAIL rst_mas got=%b want=10", MAS); end
    total++; if ({st_ack, st_done, st_abort, addr_inc, WD_Load} !== 5'b0)
      begin bad++; $display("FAIL rst_pulses got=%b want=00000", {st_ack, st_done, st_abort, addr_inc, WD_Load}); end
    @(posedge sysclk); #1 nRESET = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_exit_busy got=%b want=0", busy); end
  endtask

  task automatic test_str_word();
    logic ack; int a0, d0, dn0;
    a0 = n_ainc; d0 = n_drive; dn0 = n_done;
    wd_valid = 1'b1; nWAIT = 1'b1;
    start(5'd1, 1'b0, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL str_ack got=%b want=1", ack); end
    total++; if (WD_Load !== 1'b1 || busy !== 1'b1)
      begin bad++; $display("FAIL str_load got=%b%b want=11", WD_Load, busy); end
    tick();
    total++; if ({nMREQ, nRW, WD_DBE, MAS, addr_inc} !== 6'b011101)
      begin bad++; $display("FAIL str_drive got=%b want=011101", {nMREQ, nRW, WD_DBE, MAS, addr_inc}); end
    tick();
    total++; if (st_done !== 1'b1 || nMREQ !== 1'b1)
      begin bad++; $display("FAIL str_done got=%b%b want=11", st_done, nMREQ); end
    tick();
    total++; if (busy !== 1'b0 || st_done !== 1'b0)
      begin bad++; $display("FAIL str_idle got=%b%b want=00", busy, st_done); end
    total++; if (n_ainc - a0 != 1 || n_drive - d0 != 1 || n_done - dn0 != 1)
      begin bad++; $display("FAIL str_counts got=%0d/%0d/%0d want=1/1/1", n_ainc - a0, n_drive - d0, n_done - dn0); end
  endtask

  task automatic test_stm();
    logic ack; int n, a0, l0, dn0;
    a0 = n_ainc; l0 = n_load; dn0 = n_done;
    wd_valid = 1'b1; nWAIT = 1'b1;
    start(5'd3, 1'b0, ack);
    tick();
    total++; if (nMREQ !== 1'b0) begin bad++; $display("FAIL stm_beat1 got=%b want=0", nMREQ); end
    wd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (busy !== 1'b1 || WD_Load !== 1'b0 || nMREQ !== 1'b1)
        begin bad++; $display("FAIL stm_hold%0d got=%b%b%b want=101", i, busy, WD_Load, nMREQ); end
    end
    tick();
    wd_valid = 1'b1;
    #1;
    total++; if (WD_Load !== 1'b1 || nMREQ !== 1'b1)
      begin bad++; $display("FAIL stm_reload got=%b%b want=11", WD_Load, nMREQ); end
    tick();
    total++; if (nMREQ !== 1'b0) begin bad++; $display("FAIL stm_beat2 got=%b want=0", nMREQ); end
    wait_end(20, n);
    total++; if (n != 3) begin bad++; $display("FAIL stm_done_lat got=%0d want=3", n); end
    tick();
    total++; if (n_load - l0 != 3 || n_ainc - a0 != 3 || n_done - dn0 != 1)
      begin bad++; $display("FAIL stm_counts got=%0d/%0d/%0d want=3/3/1", n_load - l0, n_ainc - a0, n_done - dn0); end
  endtask

  task automatic test_wait();
    logic ack; int n, a0, d0, m0;
    a0 = n_ainc; d0 = n_drive; m0 = n_mas00;
    wd_valid = 1'b1;
    start(5'd1, 1'b1, ack);
    nWAIT = 1'b0; ABORT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({nMREQ, nRW, WD_DBE, MAS, addr_inc, st_abort} !== 7'b0110000)
        begin bad++; $display("FAIL wait_hold%0d got=%b want=0110000", i, {nMREQ, nRW, WD_DBE, MAS, addr_inc, st_abort}); end
    end
    tick();
    nWAIT = 1'b1; ABORT = 1'b0;
    #1;
    total++; if (addr_inc !== 1'b1 || MAS !== 2'b00)
      begin bad++; $display("FAIL wait_release got=%b%b want=100", addr_inc, MAS); end
    wait_end(5, n);
    total++; if (n != 1 || st_done !== 1'b1) begin bad++; $display("FAIL wait_done got=%0d want=1", n); end
    tick();
    total++; if (n_drive - d0 != 4 || n_mas00 - m0 != 4 || n_ainc - a0 != 1)
      begin bad++; $display("FAIL wait_counts got=%0d/%0d/%0d want=4/4/1", n_drive - d0, n_mas00 - m0, n_ainc - a0); end
  endtask

  task automatic test_abort();
    logic ack; int a0, l0, dn0, ab0;
    a0 = n_ainc; l0 = n_load; dn0 = n_done; ab0 = n_abort;
    wd_valid = 1'b1; nWAIT = 1'b1;
    start(5'd4, 1'b0, ack);
    tick(); tick(); tick();
    ABORT = 1'b1;
    #1;
    total++; if (nMREQ !== 1'b0 || addr_inc !== 1'b0)
      begin bad++; $display("FAIL abt_beat2 got=%b%b want=00", nMREQ, addr_inc); end
    tick();
    ABORT = 1'b0;
    total++; if (st_abort !== 1'b1 || st_done !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL abt_pulse got=%b%b%b want=101", st_abort, st_done, busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abt_idle got=%b want=0", busy); end
    tick(); tick();
    total++; if (n_ainc - a0 != 1 || n_load - l0 != 2 || n_abort - ab0 != 1 || n_done - dn0 != 0)
      begin bad++; $display("FAIL abt_counts got=%0d/%0d/%0d/%0d want=1/2/1/0", n_ainc - a0, n_load - l0, n_abort - ab0, n_done - dn0); end
  endtask

  task automatic test_zero();
    logic ack; int d0;
    d0 = n_drive;
    start(5'd0, 1'b0, ack);
    total++; if (ack !== 1'b1 || st_done !== 1'b1)
      begin bad++; $display("FAIL zero_done got=%b%b want=11", ack, st_done); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b want=0", busy); end
    tick();
    total++; if (n_drive - d0 != 0) begin bad++; $display("FAIL zero_nmreq got=%0d want=0", n_drive - d0); end
  endtask

  task automatic test_clamp();
    logic ack; int n, a0, d0;
    a0 = n_ainc; d0 = n_drive;
    wd_valid = 1'b1; nWAIT = 1'b1;
    start(5'd20, 1'b0, ack);
    wait_end(100, n);
    total++; if (n != 32 || st_done !== 1'b1) begin bad++; $display("FAIL clamp_lat got=%0d want=32", n); end
    tick();
    total++; if (n_ainc - a0 != 16 || n_drive - d0 != 16)
      begin bad++; $display("FAIL clamp_beats got=%0d/%0d want=16/16", n_ainc - a0, n_drive - d0); end
  endtask

  task automatic test_back_to_back();
    int n;
    wd_valid = 1'b1; nWAIT = 1'b1;
    st_req = 1'b1; st_count = 5'd1; st_byte = 1'b0;
    #1;
    total++; if (st_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b want=1", st_ack); end
    tick(); tick(); tick();
    total++; if (st_done !== 1'b1 || st_ack !== 1'b0)
      begin bad++; $display("FAIL b2b_noack_done got=%b%b want=10", st_done, st_ack); end
    tick();
    total++; if (busy !== 1'b0 || st_ack !== 1'b1)
      begin bad++; $display("FAIL b2b_ack2 got=%b%b want=01", busy, st_ack); end
    tick();
    st_req = 1'b0;
    wait_end(10, n);
    total++; if (n != 2) begin bad++; $display("FAIL b2b_second got=%0d want=2", n); end
    tick();
  endtask

  task automatic test_reset_drive();
    logic ack; int n, dn0, ab0;
    dn0 = n_done; ab0 = n_abort;
    wd_valid = 1'b1; nWAIT = 1'b1;
    start(5'd2, 1'b1, ack);
    tick();
    #3 nRESET = 1'b0;
    #1;
    total++; if ({WD_DBE, nMREQ, nRW, MAS, busy} !== 6'b010100)
      begin bad++; $display("FAIL rstd_async got=%b want=010100", {WD_DBE, nMREQ, nRW, MAS, busy}); end
    tick(); tick();
    nRESET = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstd_idle got=%b want=0", busy); end
    total++; if (n_done - dn0 != 0 || n_abort - ab0 != 0)
      begin bad++; $display("FAIL rstd_pulses got=%0d/%0d want=0/0", n_done - dn0, n_abort - ab0); end
    start(5'd1, 1'b0, ack);
    wait_end(10, n);
    total++; if (n != 2) begin bad++; $display("FAIL rstd_resume got=%0d want=2", n); end
    tick();
  endtask

  initial begin
    nRESET = 1'b0; st_req = 1'b0; st_count = '0; st_byte = 1'b0;
    wd_valid = 1'b0; nWAIT = 1'b1; ABORT = 1'b0;
    test_reset();
    test_str_word();
    test_stm();
    test_wait();
    test_abort();
    test_zero();
    test_clamp();
    test_back_to_back();
    test_reset_drive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
